// File: rtl/barrel_thread_scheduler_if.sv
// Bundles the scheduler's thread-control inputs and issue/writeback outputs.
//   master : the core-side controller. It drives thread enables and stall
//            set/clear requests and observes the issue and writeback slots.
//   slave  : the scheduler itself.
// Signals:
//   i_thread_en        per-thread enable, bit n = thread n may issue
//   i_stall_set_valid  block thread i_stall_set_tid
//   i_stall_set_tid    thread to block
//   i_stall_clr_valid  unblock thread i_stall_clr_tid
//   i_stall_clr_tid    thread to unblock
//   o_issue_valid      current slot carries a live instruction
//   o_issue_tid        thread owning the current slot
//   o_wb_valid         writeback slot is live
//   o_wb_tid           thread owning the writeback slot
//   o_stalled_mask     registered per-thread stall bits
//   o_all_idle         no thread is both enabled and unstalled
interface barrel_thread_scheduler_if #(
    parameter int NUM_THREADS = 16,
    parameter int TID_WIDTH   = $clog2(NUM_THREADS)
);
    logic [NUM_THREADS-1:0] i_thread_en;
    logic                   i_stall_set_valid;
    logic [TID_WIDTH-1:0]   i_stall_set_tid;
    logic                   i_stall_clr_valid;
    logic [TID_WIDTH-1:0]   i_stall_clr_tid;
    logic                   o_issue_valid;
    logic [TID_WIDTH-1:0]   o_issue_tid;
    logic                   o_wb_valid;
    logic [TID_WIDTH-1:0]   o_wb_tid;
    logic [NUM_THREADS-1:0] o_stalled_mask;
    logic                   o_all_idle;

    modport master (
        output i_thread_en,
        output i_stall_set_valid,
        output i_stall_set_tid,
        output i_stall_clr_valid,
        output i_stall_clr_tid,
        input  o_issue_valid,
        input  o_issue_tid,
        input  o_wb_valid,
        input  o_wb_tid,
        input  o_stalled_mask,
        input  o_all_idle
    );

    modport slave (
        input  i_thread_en,
        input  i_stall_set_valid,
        input  i_stall_set_tid,
        input  i_stall_clr_valid,
        input  i_stall_clr_tid,
        output o_issue_valid,
        output o_issue_tid,
        output o_wb_valid,
        output o_wb_tid,
        output o_stalled_mask,
        output o_all_idle
    );
endinterface

// File: rtl/barrel_thread_scheduler.sv
// Issue-slot sequencer for the barrel-threaded core.
// A fixed round-robin pointer walks over NUM_THREADS slots, one per cycle.
// Each slot is granted to its own thread only when that thread is enabled
// and not blocked on a multi-cycle operation. Slots are never handed to a
// different thread, so barrel timing stays fixed. Issued {valid, tid} pairs
// travel down a fully reset delay line to tag writeback WB_LATENCY cycles
// later.
// Ports:
//   clk    core clock
//   reset  synchronous active-high reset
//   bus    barrel_thread_scheduler_if.slave (enables, stall set/clr,
//          issue/writeback slots, stall mask, all-idle flag)
module barrel_thread_scheduler #(
    parameter int NUM_THREADS = 16,
    parameter int TID_WIDTH   = $clog2(NUM_THREADS),
    parameter int WB_LATENCY  = 8
) (
    input  logic clk,
    input  logic reset,
    barrel_thread_scheduler_if.slave bus
);

    localparam logic [TID_WIDTH-1:0] LAST_TID = TID_WIDTH'(NUM_THREADS - 1);

    logic [TID_WIDTH-1:0]   ptr;
    logic [NUM_THREADS-1:0] stall;
    logic [NUM_THREADS-1:0] stall_next;
    logic                   issue_valid;
    logic [TID_WIDTH-1:0]   issue_tid;
    logic                   wb_vld [WB_LATENCY];
    logic [TID_WIDTH-1:0]   wb_tid [WB_LATENCY];

    // Clear is applied before set, so a set and clear of the same thread in
    // one cycle leaves it stalled. Comparing against each legal thread index
    // makes out-of-range tids fall through without touching any bit.
    always_comb begin
        stall_next = stall;
        for (int n = 0; n < NUM_THREADS; n++) begin
            if (bus.i_stall_clr_valid && (bus.i_stall_clr_tid == TID_WIDTH'(n))) begin
                stall_next[n] = 1'b0;
            end
        end
        for (int n = 0; n < NUM_THREADS; n++) begin
            if (bus.i_stall_set_valid && (bus.i_stall_set_tid == TID_WIDTH'(n))) begin
                stall_next[n] = 1'b1;
            end
        end
    end

    // Issue stage: the grant uses stall_next so that a stall raised in this
    // cycle already suppresses the slot being registered now.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            stall       <= '0;
            issue_valid <= 1'b0;
            issue_tid   <= '0;
        end else begin
            stall       <= stall_next;
            issue_tid   <= ptr;
            issue_valid <= bus.i_thread_en[ptr] & ~stall_next[ptr];
            ptr         <= (ptr == LAST_TID) ? '0 : ptr + TID_WIDTH'(1);
        end
    end

    // Writeback delay line: every stage is cleared on reset so nothing issued
    // before reset can surface as a writeback afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < WB_LATENCY; k++) begin
                wb_vld[k] <= 1'b0;
                wb_tid[k] <= '0;
            end
        end else begin
            wb_vld[0] <= issue_valid;
            wb_tid[0] <= issue_tid;
            for (int k = 1; k < WB_LATENCY; k++) begin
                wb_vld[k] <= wb_vld[k-1];
                wb_tid[k] <= wb_tid[k-1];
            end
        end
    end

    assign bus.o_issue_valid  = issue_valid;
    assign bus.o_issue_tid    = issue_tid;
    assign bus.o_wb_valid     = wb_vld[WB_LATENCY-1];
    assign bus.o_wb_tid       = wb_tid[WB_LATENCY-1];
    assign bus.o_stalled_mask = stall;
    // Informational only; issue does not consult it.
    assign bus.o_all_idle     = ~|(bus.i_thread_en & ~stall);

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// Testbench for barrel_thread_scheduler: a 16-thread instance (WB_LATENCY 8)
// and a 12-thread instance run in lockstep on shared stimulus; a behavioural
// model pushes expected slots into queues that are popped after each edge.
module tb_barrel_thread_scheduler;

    typedef struct packed {
        logic       v;
        logic [3:0] t;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] en;
    logic        sv;
    logic [3:0]  st;
    logic        cv;
    logic [3:0]  ct;

    int checks   = 0;
    int failures = 0;

    int          m_ptr   [2];
    logic [15:0] m_stall [2];
    slot_t       iss_q[$];
    slot_t       iss12_q[$];
    slot_t       wb_q[$];

    always #5 clk = ~clk;

    barrel_thread_scheduler_if #(.NUM_THREADS(16), .TID_WIDTH(4)) bus ();
    barrel_thread_scheduler_if #(.NUM_THREADS(12), .TID_WIDTH(4)) bus12 ();

    assign bus.i_thread_en         = en;
    assign bus.i_stall_set_valid   = sv;
    assign bus.i_stall_set_tid     = st;
    assign bus.i_stall_clr_valid   = cv;
    assign bus.i_stall_clr_tid     = ct;
    assign bus12.i_thread_en       = en[11:0];
    assign bus12.i_stall_set_valid = sv;
    assign bus12.i_stall_set_tid   = st;
    assign bus12.i_stall_clr_valid = cv;
    assign bus12.i_stall_clr_tid   = ct;

    barrel_thread_scheduler #(.NUM_THREADS(16), .TID_WIDTH(4), .WB_LATENCY(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    barrel_thread_scheduler #(.NUM_THREADS(12), .TID_WIDTH(4), .WB_LATENCY(3)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the currently driven inputs, push the
    // expected slots, clock the DUTs, then pop and compare.
    task automatic step();
        slot_t       e;
        slot_t       exp_wb;
        int          nt;
        logic [15:0] sn;
        logic [15:0] enm;
        for (int d = 0; d < 2; d++) begin
            nt  = (d == 1) ? 12 : 16;
            enm = (d == 1) ? {4'b0, en[11:0]} : en;
            if (reset) begin
                m_ptr[d]   = 0;
                m_stall[d] = '0;
                e          = '0;
            end else begin
                sn = m_stall[d];
                if (cv && (int'(ct) < nt)) sn[ct] = 1'b0;
                if (sv && (int'(st) < nt)) sn[st] = 1'b1;
                e.v        = enm[m_ptr[d]] & ~sn[m_ptr[d]];
                e.t        = 4'(m_ptr[d]);
                m_stall[d] = sn;
                m_ptr[d]   = (m_ptr[d] == nt - 1) ? 0 : m_ptr[d] + 1;
            end
            if (d == 0) iss_q.push_back(e);
            else        iss12_q.push_back(e);
        end
        if (reset) begin
            wb_q.delete();
            for (int k = 0; k < 8; k++) wb_q.push_back('0);
            exp_wb = '0;
        end else begin
            exp_wb = wb_q.pop_front();
            wb_q.push_back(iss_q[$]);
        end

        @(posedge clk);
        #1;

        e = iss_q.pop_front();
        chk("issue_valid", 32'(bus.o_issue_valid), 32'(e.v));
        chk("issue_tid",   32'(bus.o_issue_tid),   32'(e.t));
        chk("wb_valid",    32'(bus.o_wb_valid),    32'(exp_wb.v));
        chk("wb_tid",      32'(bus.o_wb_tid),      32'(exp_wb.t));
        chk("stall_mask",  32'(bus.o_stalled_mask), 32'(m_stall[0]));
        chk("all_idle",    32'(bus.o_all_idle),    32'(~|(en & ~m_stall[0])));
        e = iss12_q.pop_front();
        chk("nt12_issue_valid", 32'(bus12.o_issue_valid),  32'(e.v));
        chk("nt12_issue_tid",   32'(bus12.o_issue_tid),    32'(e.t));
        chk("nt12_stall_mask",  32'(bus12.o_stalled_mask), 32'(m_stall[1][11:0]));

        sv = 1'b0;
        cv = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_ptr(input int p);
        for (int i = 0; i < 16 && m_ptr[0] != p; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        en    = 16'hFFFF;
        sv    = 1'b0;
        st    = '0;
        cv    = 1'b0;
        ct    = '0;

        // Reset, then full enable: tid sequence 0..15,0 and writeback 8 later.
        steps(2);
        reset = 1'b0;
        steps(26);

        // Sparse enable, then nothing enabled.
        en = 16'h0005;
        steps(16);
        en = 16'h0000;
        steps(3);
        en = 16'hFFFF;

        // Stall tid 3 in its own slot, release three cycles later.
        goto_ptr(3);
        sv = 1'b1; st = 4'd3;
        step();
        steps(3);
        cv = 1'b1; ct = 4'd3;
        step();
        steps(18);

        // Same-cycle set and clr on tid 5: set wins.
        sv = 1'b1; st = 4'd5; cv = 1'b1; ct = 4'd5;
        step();
        cv = 1'b1; ct = 4'd5;
        step();
        sv = 1'b1; st = 4'd6;
        step();
        sv = 1'b1; st = 4'd5; cv = 1'b1; ct = 4'd6;
        step();
        steps(4);

        // tid 13 is out of range for the 12-thread instance.
        sv = 1'b1; st = 4'd13;
        step();
        goto_ptr(11);
        steps(3);

        // Clear everything, fill the delay line, reset mid-flight.
        cv = 1'b1; ct = 4'd5;  step();
        cv = 1'b1; ct = 4'd13; step();
        steps(10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(12);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            en = 16'($urandom);
            sv = 1'($urandom);
            st = 4'($urandom);
            cv = 1'($urandom);
            ct = 4'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
